// File: rtl/ethernet_tx_frame_arbiter.sv
// rtl/ethernet_tx_frame_arbiter.sv - round-robin frame arbiter feeding the shared Ethernet TX path
module ethernet_tx_frame_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = 1500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 frame_trunc
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_IFG  = 2'd3;

  localparam logic [13:0]      CNT_LAST = 14'(MAX_FRAME_BYTES - 1);
  localparam logic [IFG_W-1:0] IFG_END  = IFG_W'(IFG_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant_r;
  logic [13:0]        byte_cnt;
  logic [IFG_W-1:0]   ifg_cnt;

  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;
  logic               trunc_now;
  logic               beat_acc;
  logic [PTR_W-1:0]   next_ptr;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   cand;

  assign own_valid = req_valid[owner];
  assign own_last  = req_last[owner];
  assign own_data  = req_data[{owner, 3'b000} +: 8];
  // The last permitted byte closes the frame itself unless the source already marked it last.
  assign trunc_now = (byte_cnt == CNT_LAST) & ~own_last;
  assign beat_acc  = (state == ST_XFER) & own_valid & m_ready;
  assign next_ptr  = (owner == PTR_MAX) ? '0 : owner + 1'b1;

  assign grant = grant_r;
  assign busy  = (state != ST_IDLE);

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  end

  // Owner pass-through while transferring; swallow the tail while dropping.
  always_comb begin
    req_ready = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    if (state == ST_XFER) begin
      m_valid          = own_valid;
      m_data           = own_data;
      m_last           = own_last | trunc_now;
      req_ready[owner] = m_ready;
    end else if (state == ST_DROP) begin
      req_ready[owner] = 1'b1;
    end
  end

  // Frame sequencing: arbitrate, forward, optionally drop the tail, then hold off for the gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant_r     <= '0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
      frame_trunc <= 1'b0;
    end else begin
      frame_trunc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            grant_r  <= pick_onehot;
            byte_cnt <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_acc) begin
            if (own_last) begin
              state    <= ST_IFG;
              ptr      <= next_ptr;
              grant_r  <= '0;
              byte_cnt <= '0;
              ifg_cnt  <= '0;
            end else if (trunc_now) begin
              state       <= ST_DROP;
              ptr         <= next_ptr;
              byte_cnt    <= '0;
              frame_trunc <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 14'd1;
            end
          end
        end
        ST_DROP: begin
          if (own_valid & own_last) begin
            state   <= ST_IFG;
            grant_r <= '0;
            ifg_cnt <= '0;
          end
        end
        ST_IFG: begin
          if (ifg_cnt == IFG_END) begin
            state <= ST_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
